// File: rtl/mem_access_unit.sv
// mem_access_unit
//   This is the data-memory stage of the pipeline. It contains a synchronous-read
//   RAM that holds DEPTH_WORDS words of 32 bits.
//   Stores take a single cycle.
//   Loads take two cycles:
//     - Cycle 1 is the request cycle. Stall is asserted and the RAM read is issued.
//     - Cycle 2 is the LOAD_WAIT cycle. The formatted result is presented on
//       ReadData and ReadValid pulses.
//   A misaligned access does nothing except set the sticky MisalignErr flag.
//
// Ports
//   Clk          rising-edge clock
//   Rst          synchronous reset, active low
//   MemRead      load request
//   MemWrite     store request (ignored when MemRead is also set)
//   MemSize      00 byte, 01 halfword, 10/11 word
//   MemUnsigned  1 = zero-extend loads, 0 = sign-extend
//   Address      byte address; only bits [ADDR_W+1:0] are used (wraps)
//   WriteData    right-aligned store data
//   ReadData     formatted load result; holds its value between loads
//   ReadValid    one-cycle pulse marking a fresh ReadData
//   Stall        freezes the upstream stages while a load is outstanding
//   MisalignErr  sticky flag for misaligned accesses; cleared only by reset
module mem_access_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        Stall,
    output logic        MisalignErr
);

    typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} state_t;

    state_t            state, nextState;
    logic [31:0]       mem [DEPTH_WORDS];
    logic [31:0]       ramQ;
    logic [31:0]       dataHold;
    logic [31:0]       loadFmt;
    logic [31:0]       shifted;
    logic [31:0]       wdataRep;
    logic [3:0]        byteEn;
    logic [ADDR_W-1:0] wordIdx;
    logic [1:0]        capOff;
    logic [1:0]        capSize;
    logic              capUns;
    logic              misalign;
    logic              doLoad;
    logic              doStore;
    logic              misReq;

    // Address bits above the RAM index are deliberately dropped, so that
    // addresses wrap around the RAM.
    logic unusedAddrBits;
    assign unusedAddrBits = &{1'b0, Address[31:ADDR_W+2]};

    assign wordIdx  = Address[ADDR_W+1:2];
    assign misalign = (MemSize == 2'b01 && Address[0]) ||
                      (MemSize[1] && Address[1:0] != 2'b00);

    // Store byte enables and lane-replicated write data.
    always_comb begin
        byteEn   = 4'b1111;
        wdataRep = WriteData;
        case (MemSize)
            2'b00: begin
                byteEn   = 4'b0001 << Address[1:0];
                wdataRep = {4{WriteData[7:0]}};
            end
            2'b01: begin
                byteEn   = Address[1] ? 4'b1100 : 4'b0011;
                wdataRep = {2{WriteData[15:0]}};
            end
            default: ;
        endcase
    end

    // The whole control path is gated by Rst. This keeps Stall and ReadValid
    // low during reset, and it prevents a store that coincides with reset.
    always_comb begin
        nextState = state;
        Stall     = 1'b0;
        ReadValid = 1'b0;
        doLoad    = 1'b0;
        doStore   = 1'b0;
        misReq    = 1'b0;
        if (Rst) begin
            case (state)
                IDLE: begin
                    if ((MemRead || MemWrite) && misalign) begin
                        misReq = 1'b1;
                    end else if (MemRead) begin
                        doLoad    = 1'b1;
                        Stall     = 1'b1;
                        nextState = LOAD_WAIT;
                    end else if (MemWrite) begin
                        doStore = 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    // Inputs are ignored in this state; upstream is frozen by Stall.
                    ReadValid = 1'b1;
                    nextState = IDLE;
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // RAM has no reset, so its contents survive a pipeline reset.
    always_ff @(posedge Clk) begin
        if (doStore) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wdataRep[8*b +: 8];
            end
        end
        if (doLoad) ramQ <= mem[wordIdx];
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state       <= IDLE;
            dataHold    <= '0;
            MisalignErr <= 1'b0;
            capOff      <= '0;
            capSize     <= '0;
            capUns      <= 1'b0;
        end else begin
            state <= nextState;
            if (ReadValid) dataHold    <= loadFmt;
            if (misReq)    MisalignErr <= 1'b1;
            if (doLoad) begin
                capOff  <= Address[1:0];
                capSize <= MemSize;
                capUns  <= MemUnsigned;
            end
        end
    end

    // The selected lane is moved down to bit 0. An aligned halfword has
    // capOff[0] == 0, so this one shift serves both byte and halfword loads.
    assign shifted = ramQ >> {capOff, 3'b000};

    always_comb begin
        case (capSize)
            2'b00:   loadFmt = {{24{~capUns & shifted[7]}},  shifted[7:0]};
            2'b01:   loadFmt = {{16{~capUns & shifted[15]}}, shifted[15:0]};
            default: loadFmt = ramQ;
        endcase
    end

    assign ReadData = ReadValid ? loadFmt : dataHold;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, data memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter ADDR_W, default 10, word-index width; log2(DEPTH_WORDS).
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port MemRead  input  1  load request from EX/MEM bundle.
REQ-006 SHALL have port MemWrite  input  1  store request from EX/MEM bundle.
REQ-007 SHALL have port MemSize  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
REQ-008 SHALL have port MemUnsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
REQ-009 SHALL have port Address  input  32  byte address (ALU result).
REQ-010 SHALL have port WriteData  input  32  store data, right-aligned.
REQ-011 SHALL have port ReadData  output  32  formatted load result, feeding the MEM/WB register.
REQ-012 SHALL have port ReadValid  output  1  one-cycle pulse; ReadData is valid.
REQ-013 SHALL have port Stall  output  1  hold upstream stages; MEM/WB write enable = !Stall.
REQ-014 SHALL have port MisalignErr  output  1  sticky misaligned-access flag.

Function
REQ-015 SHALL hold internal synchronous-read RAM of DEPTH_WORDS x 32; word index = Address[ADDR_W+1:2]; upper address bits ignored (wrap-around).
REQ-016 SHALL implement FSM states IDLE and LOAD_WAIT.
REQ-017 IDLE, aligned MemRead=1: Stall=1 combinationally the same cycle, RAM read issued, Address[1:0]/MemSize/MemUnsigned captured, next state LOAD_WAIT.
REQ-018 LOAD_WAIT: Stall=0; ReadData registered from RAM word, ReadValid=1 for exactly that cycle; next state IDLE; load latency = 2 cycles from request.
REQ-019 Byte load SHALL select lane Address[1:0] (little-endian: lane 0 = bits 7:0); halfword selects Address[1] (0 = bits 15:0); extend per MemUnsigned.
REQ-020 IDLE, aligned MemWrite=1, MemRead=0: single-cycle store at the edge, Stall=0, byte enables from size/lane; other bytes unchanged.
REQ-021 MemRead=1 and MemWrite=1 together: SHALL act as load only; no memory write.
REQ-022 Misaligned = halfword with Address[0]=1, or word/reserved with Address[1:0]!=00: no RAM write, no read, no Stall, no ReadValid; MisalignErr set next edge and held until reset.
REQ-023 Inputs in LOAD_WAIT SHALL be ignored (upstream held by Stall); back-to-back loads therefore occupy 2 cycles each.
REQ-024 ReadData SHALL hold its last value when ReadValid=0.
REQ-025 Neither MemRead nor MemWrite: no RAM access, outputs idle.

Reset
REQ-026 Rst=0 at an edge: state IDLE, ReadData=0, ReadValid=0, MisalignErr=0; Stall=0 while Rst=0.
REQ-027 Reset during LOAD_WAIT SHALL abort the load: no ReadValid pulse, ReadData=0.
REQ-028 Reset SHALL NOT clear RAM contents; a store coincident with Rst=0 SHALL NOT write.

Verification
REQ-029 Word store 0xDEADBEEF @0x10, then word load @0x10 -> Stall=1 cycle 1, ReadValid=1 cycle 2, ReadData=0xDEADBEEF.
REQ-030 Byte loads @0x13 of that word: MemUnsigned=0 -> 0xFFFFFFDE; MemUnsigned=1 -> 0x000000DE; halfword @0x10 signed -> 0xFFFFBEEF.
REQ-031 Byte store 0x55 @0x11 over 0xDEADBEEF, word reload -> 0xDEAD55EF.
REQ-032 Word load @0x12 -> MisalignErr=1 next cycle and sticky, Stall=0, ReadValid never pulses, RAM unchanged.
REQ-033 Load issued, Rst=0 in LOAD_WAIT -> ReadValid stays 0, ReadData=0, state IDLE; subsequent load @0x10 still returns 0xDEADBEEF.
REQ-034 Address 0x00001010 (beyond 4 KB, DEPTH_WORDS=1024) word load -> returns word at 0x010 (wrap).
